// File: rtl/ssram_dp_banked_pkg.sv
// ssram_pkg: shared constants, address-width helper and clear-sequencer states for ssram_dp_banked.
package ssram_pkg;
   localparam int LANE_W = 4;

   typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_e;

   function automatic int addr_w(input int depth);
      return ($clog2(depth) > 1) ? $clog2(depth) : 1;
   endfunction
endpackage

// File: rtl/ssram_dp_banked_if.sv
// ssram_dp_banked_if: clear/write/read bus of ssram_dp_banked; master drives requests, slave is the RAM.
interface ssram_dp_banked_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64
);
   import ssram_pkg::*;
   localparam int AW = addr_w(DEPTH);
   logic                    clr;
   logic                    busy;
   logic                    we;
   logic [WIDTH/LANE_W-1:0] wbe;
   logic [AW-1:0]           waddr;
   logic [WIDTH-1:0]        wdata;
   logic                    re;
   logic [AW-1:0]           raddr;
   logic [WIDTH-1:0]        rdata;
   logic                    rvalid;
   logic                    rerr;

   modport master (
      output clr, we, wbe, waddr, wdata, re, raddr,
      input  busy, rdata, rvalid, rerr
   );

   modport slave (
      input  clr, we, wbe, waddr, wdata, re, raddr,
      output busy, rdata, rvalid, rerr
   );
endinterface

// File: rtl/ssram_dp_banked_lane.sv
// ssram_lane: one 4-bit storage column, synchronous write and asynchronous read; the caller keeps addresses in range.
module ssram_lane #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [3:0]    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [3:0]    o_rdata
);
   logic [3:0] r_mem [DEPTH];

   always_ff @(posedge clk)
      if (i_we) r_mem[i_waddr] <= i_wdata;

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ssram_dp_banked.sv
// ssram_dp_banked: banked semi-dual-port RAM with nibble write lanes, registered read and clear sequencer.
// Define SSRAM_DP_BANKED_BYPASS_EN for write-first same-address reads (default is read-before-write).
module ssram_dp_banked
   import ssram_pkg::*;
#(
   parameter int              WIDTH = 8,
   parameter int              DEPTH = 64,
   parameter logic [WIDTH-1:0] INIT = '0
) (
   input logic              clk,
   input logic              rst_n,
   ssram_dp_banked_if.slave bus
);
   localparam int AW = addr_w(DEPTH);
   localparam int NL = WIDTH / LANE_W;
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   clr_state_e       r_state, w_state_nxt;
   logic [AW-1:0]    r_cnt, w_cnt_nxt;
   logic             w_clearing, w_last, w_wr_ok, w_rd_ok, w_rd_oor;
   logic [NL-1:0]    w_user_we, w_lane_we;
   logic [AW-1:0]    w_waddr;
   logic [WIDTH-1:0] w_wdata, w_mem_rd, w_rd_data;
   logic [WIDTH-1:0] r_rdata;
   logic             r_rvalid, r_rerr;

   assign w_clearing = r_state == CLR_RUN;
   assign w_last     = r_cnt == AW'(DEPTH-1);
   assign w_wr_ok    = bus.we && !w_clearing && ({1'b0, bus.waddr} < DEPTH_W);
   assign w_rd_ok    = bus.re && !w_clearing;
   assign w_rd_oor   = !({1'b0, bus.raddr} < DEPTH_W);
   assign w_user_we  = w_wr_ok ? bus.wbe : '0;
   // The sequencer owns the write port while clearing; user writes are gated off above.
   assign w_lane_we  = w_clearing ? '1 : w_user_we;
   assign w_waddr    = w_clearing ? r_cnt : bus.waddr;
   assign w_wdata    = w_clearing ? INIT : bus.wdata;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= CLR_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (w_clearing) begin
         w_cnt_nxt   = r_cnt + 1'b1;
         w_state_nxt = w_last ? CLR_IDLE : CLR_RUN;
      end else if (bus.clr) begin
         w_cnt_nxt   = '0;
         w_state_nxt = CLR_RUN;
      end
   end

   for (genvar g = 0; g < NL; g++) begin : g_lane
      ssram_lane #(.DEPTH(DEPTH), .AW(AW)) u_lane (
         .clk     (clk),
         .i_we    (w_lane_we[g]),
         .i_waddr (w_waddr),
         .i_wdata (w_wdata[g*LANE_W +: LANE_W]),
         .i_raddr (bus.raddr),
         .o_rdata (w_mem_rd[g*LANE_W +: LANE_W])
      );
`ifdef SSRAM_DP_BANKED_BYPASS_EN
      assign w_rd_data[g*LANE_W +: LANE_W] = (w_user_we[g] && bus.waddr == bus.raddr) ?
         bus.wdata[g*LANE_W +: LANE_W] : w_mem_rd[g*LANE_W +: LANE_W];
`else
      assign w_rd_data[g*LANE_W +: LANE_W] = w_mem_rd[g*LANE_W +: LANE_W];
`endif
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_rerr   <= 1'b0;
      end else begin
         r_rvalid <= w_rd_ok;
         r_rerr   <= w_rd_ok && w_rd_oor;
         if (w_rd_ok) r_rdata <= w_rd_oor ? '0 : w_rd_data;
      end

   assign bus.busy   = w_clearing;
   assign bus.rdata  = r_rdata;
   assign bus.rvalid = r_rvalid;
   assign bus.rerr   = r_rerr;
endmodule
